data_mem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the CPU memory stage and the DMA channel. The CPU has priority, subject to a starvation bound. DMA traffic moves as non-preemptible bursts of word accesses. While a burst runs, CPU accesses are stalled. The block sits between the memory stage and the data memory, and supplies the DMA-side `en`/`memAddr`/`memDataOut` traffic that the top level currently ties off.

---
 rtl/data_mem_arbiter_if.sv | 45 ++++
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 tb/tb_data_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the DMA channel and the data memory.
// The arbiter connects through the slave modport and its environment through master.
interface data_mem_arbiter_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [4:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_grant;
  logic        dma_beat;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_done;

  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_wr, dma_addr, dma_len, dma_wdata,
    output dma_grant, dma_beat, dma_rvalid, dma_rdata, dma_done,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_wr, dma_addr, dma_len, dma_wdata,
    input  dma_grant, dma_beat, dma_rvalid, dma_rdata, dma_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, DMA bursts are admitted when the
// CPU is idle or after STARVE_LIMIT consecutive CPU wins, and then run to completion.
module data_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  data_mem_arbiter_if.slave bus
);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LEN_W    = 5;
  localparam int unsigned MAX_LEN  = 16;

  typedef enum logic [1:0] {IDLE, DMA, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [LEN_W-1:0]    r_beat_cnt;
  logic [LEN_W-1:0]    r_len;
  logic [31:0]         r_base;
  logic                r_dir;
  logic                r_dma_grant;
  logic                r_dma_rvalid;

  logic                w_cpu_req;
  logic                w_admit;
  logic                w_beat;
  logic                w_last;
  logic [LEN_W-1:0]    w_len_clamp;
  logic                w_unused;

  assign w_cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign w_len_clamp = (bus.dma_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.dma_len;
  assign w_admit     = (r_state == IDLE) && bus.dma_req &&
                       (!w_cpu_req || (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));
  assign w_beat      = (r_state == DMA) && (r_len != '0);
  assign w_last      = (r_len == '0) || (r_beat_cnt == (r_len - LEN_W'(1)));
  assign w_unused    = &{1'b0, bus.dma_addr[1:0]};

  // Read data is a straight pass-through; requesters use stall/rvalid to qualify it.
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.dma_grant  = r_dma_grant;
  assign bus.dma_rvalid = r_dma_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.cpu_stall = 1'b0;
    bus.dma_beat  = 1'b0;
    bus.dma_done  = 1'b0;
    bus.mem_en    = w_cpu_req;
    bus.mem_wr    = bus.cpu_wr;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    case (r_state)
      IDLE: begin
        if (w_admit) w_state_nxt = DMA;
      end
      DMA: begin
        bus.cpu_stall = w_cpu_req;
        bus.dma_beat  = w_beat;
        bus.mem_en    = w_beat;
        bus.mem_wr    = w_beat & r_dir;
        bus.mem_addr  = r_base + 32'({r_beat_cnt, 2'b00});
        bus.mem_wdata = bus.dma_wdata;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.cpu_stall = w_cpu_req;
        bus.dma_done  = 1'b1;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst context, starvation counter and registered DMA status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_beat_cnt   <= '0;
      r_len        <= '0;
      r_base       <= '0;
      r_dir        <= 1'b0;
      r_dma_grant  <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_grant  <= w_admit;
      r_dma_rvalid <= w_beat & ~r_dir;

      if (!bus.dma_req || w_admit) begin
        r_starve_cnt <= '0;
      end else if ((r_state == IDLE) && w_cpu_req &&
                   (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end

      if (w_admit) begin
        r_base     <= {bus.dma_addr[31:2], 2'b00};
        r_len      <= w_len_clamp;
        r_dir      <= bus.dma_wr;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random traffic,
// all compared against a timeline model of admission, beats and done.
module tb_data_mem_arbiter;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;

  data_mem_arbiter_if bus();

  data_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        grant;
    logic        beat;
    logic        rvalid;
    logic        done;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] crd;
    logic [31:0] drd;
  } out_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: a burst admitted in cycle T with L beats owns cycles T+1 .. T+max(L,1)+1.
  bit          m_in_burst, m_dir, m_prev_rd, m_beat_rd, m_admitted;
  int          m_cycle, m_t, m_l, m_starve;
  logic [31:0] m_base;

  bit          pending;
  logic        p_wr;
  logic [31:0] p_addr;
  logic [4:0]  p_len;

  function automatic out_t observe();
    out_t o;
    o.stall  = bus.cpu_stall;
    o.grant  = bus.dma_grant;
    o.beat   = bus.dma_beat;
    o.rvalid = bus.dma_rvalid;
    o.done   = bus.dma_done;
    o.en     = bus.mem_en;
    o.wr     = bus.mem_wr;
    o.addr   = bus.mem_addr;
    o.wdata  = bus.mem_wdata;
    o.crd    = bus.cpu_rdata;
    o.drd    = bus.dma_rdata;
    return o;
  endfunction

  function automatic out_t masked(input out_t v, input logic en);
    out_t r = v;
    if (!en) begin
      r.addr  = '0;
      r.wdata = '0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_in_burst = 0; m_dir = 0; m_prev_rd = 0; m_beat_rd = 0; m_admitted = 0;
    m_cycle = 0; m_t = 0; m_l = 0; m_starve = 0; m_base = '0;
  endtask

  task automatic model_eval(output out_t e);
    int k, d;
    logic cpu_req;
    cpu_req = bus.cpu_rd | bus.cpu_wr;
    e = '0;
    e.crd    = bus.mem_rdata;
    e.drd    = bus.mem_rdata;
    e.rvalid = m_prev_rd;
    if (!m_in_burst) begin
      e.en    = cpu_req;
      e.wr    = bus.cpu_wr;
      e.addr  = bus.cpu_addr;
      e.wdata = bus.cpu_wdata;
    end else begin
      k = m_cycle - m_t;
      d = (m_l == 0) ? 1 : m_l;
      e.stall = cpu_req;
      e.grant = (k == 1);
      e.beat  = (m_l > 0) && (k <= m_l);
      e.done  = (k == d + 1);
      e.en    = e.beat;
      e.wr    = e.beat & m_dir;
      e.addr  = m_base + 32'(4 * (k - 1));
      e.wdata = bus.dma_wdata;
    end
    e = masked(e, e.en);
    m_beat_rd = e.beat && !m_dir;
  endtask

  task automatic model_commit();
    int d;
    logic cpu_req;
    cpu_req = bus.cpu_rd | bus.cpu_wr;
    m_admitted = 0;
    m_prev_rd  = m_beat_rd;
    if (m_in_burst) begin
      d = (m_l == 0) ? 1 : m_l;
      if (m_cycle - m_t == d + 1) m_in_burst = 0;
      if (!bus.dma_req) m_starve = 0;
    end else if (!bus.dma_req) begin
      m_starve = 0;
    end else if (!cpu_req || m_starve >= STARVE_LIMIT) begin
      m_in_burst = 1; m_admitted = 1; m_t = m_cycle;
      m_l    = (bus.dma_len > 5'd16) ? 16 : int'(bus.dma_len);
      m_base = bus.dma_addr & 32'hFFFF_FFFC;
      m_dir  = bus.dma_wr;
      m_starve = 0;
    end else begin
      m_starve++;
    end
    m_cycle++;
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic cpu_idle();
    cpu_set(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic start_dma(input logic wr, input logic [31:0] a, input logic [4:0] len);
    pending = 1; p_wr = wr; p_addr = a; p_len = len;
  endtask

  // One clock: drive DMA side, predict, sample at negedge, advance model at posedge.
  task automatic tick(output out_t obs, output out_t exp);
    bus.dma_req   = pending;
    bus.dma_wr    = p_wr;
    bus.dma_addr  = p_addr;
    bus.dma_len   = p_len;
    bus.dma_wdata = $urandom;
    bus.mem_rdata = $urandom;
    model_eval(exp);
    @(negedge clk);
    obs = masked(observe(), exp.en);
    @(posedge clk);
    model_commit();
    if (m_admitted) pending = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    out_t o, e;
    model_reset();
    cpu_set(1'b1, 1'b0, $urandom, $urandom);
    #1; model_eval(e); o = masked(observe(), e.en);
    n_checks++;
    if (o !== e) begin n_fails++; $display("FAIL reset_rd dut=%h model=%h", o, e); end
    cpu_set(1'b0, 1'b1, $urandom, $urandom);
    #1; model_eval(e); o = masked(observe(), e.en);
    n_checks++;
    if (o !== e) begin n_fails++; $display("FAIL reset_wr dut=%h model=%h", o, e); end
    cpu_idle();
    release_reset();
    for (int c = 0; c < 6; c++) begin
      cpu_set(1'(c % 2), 1'((c + 1) % 2), $urandom, $urandom);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL idle_cpu c=%0d dut=%h model=%h", c, o, e); end
    end
  endtask

  task automatic test_write_burst();
    out_t o, e;
    int g = -1, d = -1, nb = 0;
    bit allwr = 1;
    logic [31:0] seen [0:15];
    cpu_idle();
    start_dma(1'b1, 32'h100, 5'd4);
    for (int c = 0; c < 8; c++) begin
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL write_burst c=%0d dut=%h model=%h", c, o, e); end
      if (o.grant && g < 0) g = c;
      if (o.done && d < 0) d = c;
      if (o.beat) begin
        if (nb < 16) seen[nb] = o.addr;
        nb++;
        allwr &= o.wr;
      end
    end
    n_checks++;
    if (g != 1) begin n_fails++; $display("FAIL write_grant_cycle got=%0d want=1", g); end
    n_checks++;
    if (d != 5) begin n_fails++; $display("FAIL write_done_cycle got=%0d want=5", d); end
    n_checks++;
    if (nb != 4 || !allwr) begin n_fails++; $display("FAIL write_beats got=%0d allwr=%0d want=4/1", nb, allwr); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (seen[i] !== 32'h100 + 32'(4 * i))
        begin n_fails++; $display("FAIL write_addr%0d got=%h want=%h", i, seen[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_read_wrap();
    out_t o, e;
    logic [31:0] bases [0:1];
    logic [31:0] want1 [0:1];
    bases[0] = 32'h0FFF_FFFC; want1[0] = 32'h1000_0000;
    bases[1] = 32'hFFFF_FFFC; want1[1] = 32'h0000_0000;
    cpu_idle();
    for (int b = 0; b < 2; b++) begin
      int nb = 0, nrv = 0, rv0 = -1;
      logic [31:0] a0 = 'x, a1 = 'x;
      start_dma(1'b0, bases[b], 5'd2);
      for (int c = 0; c < 6; c++) begin
        tick(o, e);
        n_checks++;
        if (o !== e) begin n_fails++; $display("FAIL read_wrap%0d c=%0d dut=%h model=%h", b, c, o, e); end
        if (o.beat) begin
          if (nb == 0) a0 = o.addr; else a1 = o.addr;
          nb++;
        end
        if (o.rvalid) begin
          if (rv0 < 0) rv0 = c;
          nrv++;
        end
      end
      n_checks++;
      if (a0 !== bases[b] || a1 !== want1[b])
        begin n_fails++; $display("FAIL read_addr%0d got=%h,%h want=%h,%h", b, a0, a1, bases[b], want1[b]); end
      n_checks++;
      if (nrv != 2 || rv0 != 2) begin n_fails++; $display("FAIL read_rvalid%0d got=%0d@%0d want=2@2", b, nrv, rv0); end
    end
  endtask

  task automatic test_starvation();
    out_t o, e;
    int g = -1, ns = 0;
    start_dma(1'b0, $urandom, 5'd3);
    for (int c = 0; c < 16; c++) begin
      cpu_set(1'b1, 1'b0, $urandom, $urandom);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL starvation c=%0d dut=%h model=%h", c, o, e); end
      if (o.grant && g < 0) g = c;
      if (o.stall) ns++;
    end
    n_checks++;
    if (g != STARVE_LIMIT + 1) begin n_fails++; $display("FAIL starve_grant got=%0d want=%0d", g, STARVE_LIMIT + 1); end
    n_checks++;
    if (ns != 4) begin n_fails++; $display("FAIL starve_stall_cycles got=%0d want=4", ns); end
    cpu_idle();
  endtask

  task automatic test_cpu_write_stall();
    out_t o, e;
    int ns = 0, served = -1;
    out_t so = '0;
    logic [31:0] wd = $urandom;
    cpu_idle();
    start_dma(1'b1, $urandom, 5'd3);
    for (int c = 0; c < 9; c++) begin
      if (c == 1) cpu_set(1'b0, 1'b1, 32'h40, wd);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL cpu_wr_stall c=%0d dut=%h model=%h", c, o, e); end
      if (c >= 1 && served < 0) begin
        if (o.stall) ns++;
        else begin served = c; so = o; cpu_idle(); end
      end
    end
    n_checks++;
    if (ns != 4 || served != 5) begin n_fails++; $display("FAIL cpu_wr_stall_len got=%0d@%0d want=4@5", ns, served); end
    n_checks++;
    if (!so.en || !so.wr || so.addr !== 32'h40 || so.wdata !== wd)
      begin n_fails++; $display("FAIL cpu_wr_served got=%0d%0d %h %h want=11 00000040 %h", so.en, so.wr, so.addr, so.wdata, wd); end
  endtask

  task automatic test_len_edges();
    out_t o, e;
    int lens [0:1];
    int wantb [0:1];
    lens[0] = 0;  wantb[0] = 0;
    lens[1] = 20; wantb[1] = 16;
    cpu_idle();
    for (int b = 0; b < 2; b++) begin
      int nb = 0, d = -1;
      logic en_g = 1'b1;
      start_dma(1'b1, $urandom, 5'(lens[b]));
      for (int c = 0; c < 20; c++) begin
        tick(o, e);
        n_checks++;
        if (o !== e) begin n_fails++; $display("FAIL len%0d c=%0d dut=%h model=%h", lens[b], c, o, e); end
        if (o.grant) en_g = o.en;
        if (o.beat) nb++;
        if (o.done && d < 0) d = c;
      end
      n_checks++;
      if (nb != wantb[b] || d != wantb[b] + (wantb[b] == 0 ? 2 : 1))
        begin n_fails++; $display("FAIL len%0d_beats got=%0d done@%0d want=%0d", lens[b], nb, d, wantb[b]); end
      if (lens[b] == 0) begin
        n_checks++;
        if (en_g !== 1'b0) begin n_fails++; $display("FAIL len0_mem_en got=%0d want=0", en_g); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    out_t o, e;
    int nb = 0, nd = 0;
    cpu_idle();
    start_dma(1'b1, 32'h200, 5'd8);
    for (int c = 0; c < 3; c++) begin
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL pre_reset c=%0d dut=%h model=%h", c, o, e); end
    end
    cpu_set(1'b1, 1'b0, 32'h300, $urandom);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    model_eval(e);
    o = masked(observe(), e.en);
    n_checks++;
    if (o !== e) begin n_fails++; $display("FAIL mid_reset dut=%h model=%h", o, e); end
    cpu_idle();
    release_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 4) start_dma(1'b1, 32'h200, 5'd8);
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL post_reset c=%0d dut=%h model=%h", c, o, e); end
      if (o.beat) nb++;
      if (o.done) nd++;
    end
    n_checks++;
    if (nb != 8 || nd != 1) begin n_fails++; $display("FAIL post_reset_burst beats=%0d done=%0d want=8/1", nb, nd); end
  endtask

  task automatic test_random();
    out_t o, e;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        1:       cpu_set(1'b1, 1'b0, $urandom, $urandom);
        2:       cpu_set(1'b0, 1'b1, $urandom, $urandom);
        default: cpu_idle();
      endcase
      if (!pending && $urandom_range(0, 7) == 0)
        start_dma(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)));
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL random c=%0d dut=%h model=%h", c, o, e); end
    end
    cpu_idle();
    for (int c = 0; c < 40 && (pending || m_in_burst); c++) begin
      tick(o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL drain c=%0d dut=%h model=%h", c, o, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pending = 0; p_wr = 1'b0; p_addr = '0; p_len = '0;
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_len = '0;
    bus.dma_wdata = '0; bus.mem_rdata = '0;
    cpu_set(1'b0, 1'b0, '0, '0);
    model_reset();
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_starvation();
    test_cpu_write_stall();
    test_len_edges();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
